adder_share_arb: RTL and testbench

//  Owns the single 16-bit hierarchical CLA adder and shares it between two requesters
//  (req0 = EX-stage ALU, req1 = branch/PC-target path) with round-robin arbitration.

---
 rtl/adder_share_arb_pkg.sv | 32 +++
 rtl/adder_share_arb_if.sv | 69 ++++++
 rtl/adder_share_arb_rr_arb2.sv | 31 +++
 rtl/adder_share_arb.sv | 185 ++++++++++++++++++
 tb/tb_adder_share_arb.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_share_arb_pkg.sv
// -----------------------------------------------------------------------------
// adder_share_arb_pkg
// Shared definitions for the adder-sharing arbiter: default datapath width,
// adder mode encodings, FSM state encoding and a small flag helper.
// Optional feature macro used by the block: ADD_FLAGS_EN (N/Z/V response flags).
// -----------------------------------------------------------------------------
package adder_share_arb_pkg;

    localparam int unsigned WIDTH_DEFAULT = 16;
    localparam int unsigned FLAGS_W       = 3;

    // Requester mode field; 11 is reserved and behaves as a plain ADD.
    typedef enum logic [1:0] {
        MODE_ADD    = 2'b00,
        MODE_PADDSB = 2'b01,
        MODE_RED    = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Two's-complement overflow of an addition, only meaningful for ADD-class ops.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                     input logic s_msb, input logic is_add);
        return is_add & (a_msb == b_msb) & (s_msb != a_msb);
    endfunction

endpackage : adder_share_arb_pkg

// File: rtl/adder_share_arb_if.sv
// -----------------------------------------------------------------------------
// adder_share_arb_if
// Bundles the two requester ports, the shared-adder connection and the
// response port of adder_share_arb.
//   reqN_valid/ready/a/b/cin/mode : requester N (0 = EX ALU, 1 = branch/PC path)
//   add_a/b/cin/sat/red, add_s    : operands to / sum from the external adder
//   rsp_valid/ready/id/sum        : registered response with backpressure
//   rsp_flags                     : {N,Z,V}, present only with ADD_FLAGS_EN
// Modports: slave = the arbiter block, master = its environment.
// -----------------------------------------------------------------------------
interface adder_share_arb_if #(
    parameter int unsigned WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;
    logic [1:0]       req0_mode;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;
    logic [1:0]       req1_mode;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic             add_sat;
    logic             add_red;
    logic [WIDTH-1:0] add_s;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_sum;
`ifdef ADD_FLAGS_EN
    logic [2:0]       rsp_flags;
`endif

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin, req0_mode,
        input  req1_valid, req1_a, req1_b, req1_cin, req1_mode,
        output req0_ready, req1_ready,
        output add_a, add_b, add_cin, add_sat, add_red,
        input  add_s,
`ifdef ADD_FLAGS_EN
        output rsp_flags,
`endif
        output rsp_valid, rsp_id, rsp_sum,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin, req0_mode,
        output req1_valid, req1_a, req1_b, req1_cin, req1_mode,
        input  req0_ready, req1_ready,
        input  add_a, add_b, add_cin, add_sat, add_red,
        output add_s,
`ifdef ADD_FLAGS_EN
        input  rsp_flags,
`endif
        input  rsp_valid, rsp_id, rsp_sum,
        output rsp_ready
    );

endinterface : adder_share_arb_if

// File: rtl/adder_share_arb_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant. Grants only while the accept window is open.
//   valid   in  2  request valids {req1, req0}
//   rr_last in  1  index of the most recently accepted requester
//   acc     in  1  accept window open this cycle
//   gnt     out 2  one-hot (or zero) grant {req1, req0}
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       rr_last,
    input  logic       acc,
    output logic [1:0] gnt
);

    // Grant selection: lone requester wins, on contention the one not served last.
    always_comb begin
        gnt = 2'b00;
        if (acc) begin
            case (valid)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end else begin
            gnt = 2'b00;
        end
    end

endmodule : rr_arb2

// File: rtl/adder_share_arb.sv
// -----------------------------------------------------------------------------
// adder_share_arb
// Shares one external WIDTH-bit CLA adder between two requesters with
// round-robin arbitration. An accepted request is latched, presented to the
// adder for exactly one cycle (EXEC) and the sum is captured into a response
// register held under valid/ready backpressure (RESP). Accept-to-rsp_valid
// latency is two cycles; a response handshake may overlap a new accept.
// Ports:
//   clk   in  clock, rising edge
//   rst_n in  asynchronous active-low reset; drops any in-flight operation
//   bus   adder_share_arb_if.slave (requesters, adder link, response)
// Configuration: ADD_FLAGS_EN adds registered {N,Z,V} flags on bus.rsp_flags.
// -----------------------------------------------------------------------------
module adder_share_arb
    import adder_share_arb_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    adder_share_arb_if.slave   bus
);

    state_e           state_r;
    state_e           state_nxt_s;
    logic             rr_last_r;
    logic             acc_s;
    logic [1:0]       gnt_s;
    logic             fire_s;

    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;
    logic             sel_cin_s;
    logic [1:0]       sel_mode_s;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             cin_r;
    logic             sat_r;
    logic             red_r;
    logic             id_r;

    logic             rsp_valid_r;
    logic             rsp_id_r;
    logic [WIDTH-1:0] rsp_sum_r;
`ifdef ADD_FLAGS_EN
    logic [FLAGS_W-1:0] rsp_flags_r;
`endif

    // Accept window: idle, or the pending response leaves this very cycle.
    assign acc_s  = (state_r == ST_IDLE) | ((state_r == ST_RESP) & bus.rsp_ready);
    assign fire_s = |gnt_s;

    rr_arb2 u_rr_arb2 (
        .valid   ({bus.req1_valid, bus.req0_valid}),
        .rr_last (rr_last_r),
        .acc     (acc_s),
        .gnt     (gnt_s)
    );

    assign bus.req0_ready = gnt_s[0];
    assign bus.req1_ready = gnt_s[1];

    // Operand mux of the granted requester (don't-care when nothing is granted).
    always_comb begin
        sel_a_s    = bus.req0_a;
        sel_b_s    = bus.req0_b;
        sel_cin_s  = bus.req0_cin;
        sel_mode_s = bus.req0_mode;
        if (gnt_s[1]) begin
            sel_a_s    = bus.req1_a;
            sel_b_s    = bus.req1_b;
            sel_cin_s  = bus.req1_cin;
            sel_mode_s = bus.req1_mode;
        end else begin
            sel_a_s    = bus.req0_a;
            sel_b_s    = bus.req0_b;
            sel_cin_s  = bus.req0_cin;
            sel_mode_s = bus.req0_mode;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: EXEC always lasts one cycle; RESP can chain straight into EXEC.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fire_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    if (fire_s) begin
                        state_nxt_s = ST_EXEC;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Request latch: also the adder drive, so add_* only move on an accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            cin_r     <= 1'b0;
            sat_r     <= 1'b0;
            red_r     <= 1'b0;
            id_r      <= 1'b0;
            rr_last_r <= 1'b1;
        end else if (fire_s) begin
            a_r       <= sel_a_s;
            b_r       <= sel_b_s;
            cin_r     <= sel_cin_s;
            sat_r     <= (mode_e'(sel_mode_s) == MODE_PADDSB);
            red_r     <= (mode_e'(sel_mode_s) == MODE_RED);
            id_r      <= gnt_s[1];
            rr_last_r <= gnt_s[1];
        end
    end

    // Response register: capture in EXEC, release on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_sum_r   <= {WIDTH{1'b0}};
        end else if (state_r == ST_EXEC) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= id_r;
            rsp_sum_r   <= bus.add_s;
        end else if ((state_r == ST_RESP) && bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end
    end

`ifdef ADD_FLAGS_EN
    // Flag register: {N,Z,V}; V only for ADD-class ops (neither sat nor red latched).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_flags_r <= {FLAGS_W{1'b0}};
        end else if (state_r == ST_EXEC) begin
            rsp_flags_r <= {bus.add_s[WIDTH-1],
                            (bus.add_s == {WIDTH{1'b0}}),
                            add_ovf(a_r[WIDTH-1], b_r[WIDTH-1], bus.add_s[WIDTH-1],
                                    ~sat_r & ~red_r)};
        end
    end

    assign bus.rsp_flags = rsp_flags_r;
`endif

    assign bus.add_a     = a_r;
    assign bus.add_b     = b_r;
    assign bus.add_cin   = cin_r;
    assign bus.add_sat   = sat_r;
    assign bus.add_red   = red_r;

    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_sum   = rsp_sum_r;

endmodule : adder_share_arb

// File: tb/tb_adder_share_arb.sv
// -----------------------------------------------------------------------------
// tb_adder_share_arb
// Self-checking bench for adder_share_arb. A bench-side adder closes the
// add_* -> add_s loop with a plain modulo sum. Accepted requests are turned
// into expected responses on a scoreboard queue; responses are popped and
// compared on handshake. A vector table covers the modes, followed by
// hand-written sequences for arbitration, backpressure, back-to-back and reset.
// -----------------------------------------------------------------------------
module tb_adder_share_arb;
    import adder_share_arb_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    adder_share_arb_if #(.WIDTH(W)) bus ();

    adder_share_arb #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Bench-side adder: modulo sum with carry-in, mode bits not interpreted.
    assign bus.add_s = bus.add_a + bus.add_b + {{(W-1){1'b0}}, bus.add_cin};

    typedef struct {
        logic [W-1:0] sum;
        logic         id;
        logic [2:0]   flags;
        int           acc_cyc;
    } exp_t;

    typedef struct {
        logic         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [1:0]   mode;
        logic [W-1:0] exp_sum;
        logic [2:0]   exp_flags;
        logic         exp_sat;
        logic         exp_red;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[8];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic [1:0] mode, input int c);
        exp_t         e;
        logic [W-1:0] s;
        logic         is_add;
        s       = a + b + {{(W-1){1'b0}}, cin};
        is_add  = (mode == 2'b00) || (mode == 2'b11);
        e.sum   = s;
        e.id    = id;
        e.flags = {s[W-1], (s == {W{1'b0}}), is_add && (a[W-1] == b[W-1]) && (s[W-1] != a[W-1])};
        e.acc_cyc = c;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor, sampling on the falling edge.
    logic         prev_valid = 1'b0;
    logic         prev_fire  = 1'b0;
    logic [W-1:0] prev_sum   = '0;
    logic         prev_id    = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb_q.delete();
            prev_valid <= 1'b0;
            prev_fire  <= 1'b0;
        end else begin
            chk("ready_onehot", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
            chk("ready_without_valid", {31'd0, (bus.req0_ready & ~bus.req0_valid) |
                                               (bus.req1_ready & ~bus.req1_valid)}, 32'd0);
            if (prev_valid && !prev_fire) begin
                chk("stall_valid_held", {31'd0, bus.rsp_valid}, 32'd1);
                chk("stall_sum_held", {16'd0, bus.rsp_sum}, {16'd0, prev_sum});
                chk("stall_id_held", {31'd0, bus.rsp_id}, {31'd0, prev_id});
            end else if (bus.rsp_valid) begin
                chk("unexpected_rsp", sb_q.size(), 32'd1);
                if (sb_q.size() != 0) begin
                    chk("rsp_latency", cyc - sb_q[0].acc_cyc, 32'd2);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready && sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_sum", {16'd0, bus.rsp_sum}, {16'd0, e.sum});
                chk("sb_id", {31'd0, bus.rsp_id}, {31'd0, e.id});
`ifdef ADD_FLAGS_EN
                chk("sb_flags", {29'd0, bus.rsp_flags}, {29'd0, e.flags});
`endif
            end
            if (bus.req0_valid && bus.req0_ready)
                sb_q.push_back(model(1'b0, bus.req0_a, bus.req0_b, bus.req0_cin, bus.req0_mode, cyc));
            if (bus.req1_valid && bus.req1_ready)
                sb_q.push_back(model(1'b1, bus.req1_a, bus.req1_b, bus.req1_cin, bus.req1_mode, cyc));
            prev_valid <= bus.rsp_valid;
            prev_fire  <= bus.rsp_valid & bus.rsp_ready;
            prev_sum   <= bus.rsp_sum;
            prev_id    <= bus.rsp_id;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic [1:0] mode);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin; bus.req0_mode = mode;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin; bus.req1_mode = mode;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        chk({tag, "_rsp_sum"}, {16'd0, bus.rsp_sum}, 32'd0);
        chk({tag, "_rsp_id"}, {31'd0, bus.rsp_id}, 32'd0);
        chk({tag, "_add_a"}, {16'd0, bus.add_a}, 32'd0);
        chk({tag, "_add_b"}, {16'd0, bus.add_b}, 32'd0);
        chk({tag, "_add_ctl"}, {29'd0, bus.add_cin, bus.add_sat, bus.add_red}, 32'd0);
`ifdef ADD_FLAGS_EN
        chk({tag, "_flags"}, {29'd0, bus.rsp_flags}, 32'd0);
`endif
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb_q.size() != 0 || bus.rsp_valid) && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_drain_queue"}, sb_q.size(), 32'd0);
        chk({tag, "_drain_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b0, 16'h0003, 16'h0004, 1'b0, 2'b00, 16'h0007, 3'b000, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 16'h7FFF, 16'h0001, 1'b0, 2'b00, 16'h8000, 3'b101, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 2'b00, 16'h0000, 3'b010, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 16'h1234, 16'h1111, 1'b1, 2'b00, 16'h2346, 3'b000, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 16'h7000, 16'h2000, 1'b0, 2'b01, 16'h9000, 3'b100, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 16'h8000, 16'h8000, 1'b0, 2'b10, 16'h0000, 3'b010, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 2'b11, 16'h0000, 3'b011, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 16'hFFFE, 16'h0000, 1'b1, 2'b10, 16'hFFFF, 3'b100, 1'b0, 1'b1};

        set_req(0, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'b00);
        set_req(1, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'b00);
        bus.rsp_ready = 1'b1;
        do_reset();

        // Vector table: single requests, one at a time, consumer always ready.
        for (int i = 0; i < 8; i++) begin
            set_req(int'(tbl[i].id), 1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].mode);
            @(negedge clk);
            chk("tbl_ready", {30'd0, bus.req1_ready, bus.req0_ready}, tbl[i].id ? 32'd2 : 32'd1);
            tick();
            set_req(int'(tbl[i].id), 1'b0, 16'h0000, 16'h0000, 1'b0, 2'b00);
            @(negedge clk);
            chk("tbl_exec_add_a", {16'd0, bus.add_a}, {16'd0, tbl[i].a});
            chk("tbl_exec_add_b", {16'd0, bus.add_b}, {16'd0, tbl[i].b});
            chk("tbl_exec_ctl", {29'd0, bus.add_cin, bus.add_sat, bus.add_red},
                {29'd0, tbl[i].cin, tbl[i].exp_sat, tbl[i].exp_red});
            chk("tbl_exec_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
            tick();
            @(negedge clk);
            chk("tbl_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("tbl_rsp_sum", {16'd0, bus.rsp_sum}, {16'd0, tbl[i].exp_sum});
            chk("tbl_rsp_id", {31'd0, bus.rsp_id}, {31'd0, tbl[i].id});
`ifdef ADD_FLAGS_EN
            chk("tbl_rsp_flags", {29'd0, bus.rsp_flags}, {29'd0, tbl[i].exp_flags});
`endif
            tick();
            @(negedge clk);
            chk("tbl_back_idle", {31'd0, bus.rsp_valid}, 32'd0);
            tick();
        end
        drain("tbl");

        // Both requesters valid every cycle: grants 0,1,0,1 every second cycle.
        do_reset();
        set_req(0, 1'b1, 16'h0100, 16'h0001, 1'b0, 2'b00);
        set_req(1, 1'b1, 16'h0200, 16'h0002, 1'b0, 2'b00);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_ready0", {31'd0, bus.req0_ready}, (k % 4 == 0) ? 32'd1 : 32'd0);
            chk("rr_ready1", {31'd0, bus.req1_ready}, (k % 4 == 2) ? 32'd1 : 32'd0);
            tick();
        end
        set_req(0, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'b00);
        set_req(1, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'b00);
        drain("rr");

        // req1 PADDSB with a 5-cycle stall, then back-to-back with req0.
        bus.rsp_ready = 1'b0;
        set_req(1, 1'b1, 16'h7000, 16'h2000, 1'b0, 2'b01);
        @(negedge clk);
        chk("sat_ready1", {31'd0, bus.req1_ready}, 32'd1);
        tick();
        set_req(1, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'b00);
        set_req(0, 1'b1, 16'h0010, 16'h0020, 1'b0, 2'b00);
        @(negedge clk);
        chk("sat_exec_flags", {30'd0, bus.add_sat, bus.add_red}, 32'd2);
        chk("sat_exec_ready0", {31'd0, bus.req0_ready}, 32'd0);
        tick();
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("stall_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("stall_rsp_sum", {16'd0, bus.rsp_sum}, 32'h9000);
            chk("stall_rsp_id", {31'd0, bus.rsp_id}, 32'd1);
            chk("stall_no_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
            chk("stall_sat_held", {31'd0, bus.add_sat}, 32'd1);
            tick();
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("b2b_ready0", {31'd0, bus.req0_ready}, 32'd1);
        tick();
        @(negedge clk);
        chk("b2b_exec_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        chk("b2b_exec_add_a", {16'd0, bus.add_a}, 32'h0010);
        chk("b2b_exec_sat", {31'd0, bus.add_sat}, 32'd0);
        tick();
        set_req(0, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'b00);
        @(negedge clk);
        chk("b2b_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("b2b_rsp_sum", {16'd0, bus.rsp_sum}, 32'h0030);
        chk("b2b_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
        tick();
        drain("b2b");

        // Asynchronous reset in EXEC drops the operation.
        set_req(1, 1'b1, 16'h1111, 16'h2222, 1'b1, 2'b01);
        @(negedge clk);
        chk("rst_pre_ready1", {31'd0, bus.req1_ready}, 32'd1);
        tick();
        set_req(1, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'b00);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_exec");
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            chk("rst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
            tick();
        end
        set_req(0, 1'b1, 16'h0005, 16'h0006, 1'b0, 2'b00);
        set_req(1, 1'b1, 16'h0007, 16'h0008, 1'b0, 2'b00);
        @(negedge clk);
        chk("rst_first_grant", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd1);
        tick();
        set_req(0, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'b00);
        set_req(1, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'b00);
        drain("rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_adder_share_arb
